pyjamask96_arbiter: RTL and testbench

- Shares one byte-serial pyjamask96 core between two block requesters (requester 0 and requester 1).
- Each requester hands over a parallel 96-bit plaintext and a 128-bit key through a valid/ready handshake.
- The arbiter grants round-robin, serialises the operands into the core, starts the core and collects the 12 output bytes.
- It returns the 96-bit ciphertext to the granted requester through a valid/ready response.

---
 rtl/pyjamask96_pkg.sv | 25 ++
 rtl/pyjamask96_rr2.sv | 29 ++
 rtl/pyjamask96_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_pyjamask96_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pyjamask96_pkg.sv
// ============================================================================
// pyjamask96_pkg : shared byte counts, FSM encoding and watchdog default
// Rev 1.0
// ============================================================================
`default_nettype none

package pyjamask96_pkg;

  localparam int PT_BYTES           = 12;
  localparam int KEY_BYTES          = 16;
  localparam int CT_BYTES           = 12;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COLLECT = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pyjamask96_rr2.sv
// ============================================================================
// pyjamask96_rr2 : two-way round-robin picker, combinational grant
// Rev 1.0
// ============================================================================
`default_nettype none

module pyjamask96_rr2
  import pyjamask96_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_any,
  output logic       o_id
);

  // i_ptr names the favoured requester, i.e. the complement of the last grant
  always_comb begin
    o_any = |i_req;
    o_id  = 1'b0;
    if (&i_req) begin
      o_id = i_ptr;
    end else if (i_req[1]) begin
      o_id = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pyjamask96_arbiter.sv
// ============================================================================
// pyjamask96_arbiter : shares one byte-serial pyjamask96 core between two
// requesters; optional core watchdog enabled by PYJ_ARB_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module pyjamask96_arbiter
  import pyjamask96_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [95:0]     req_pt0,
  input  logic [95:0]     req_pt1,
  input  logic [127:0]    req_key0,
  input  logic [127:0]    req_key1,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [95:0]     rsp_ct,
  output logic            rsp_err,
  output logic            core_load,
  output logic            core_start,
  output logic [7:0]      core_byte_in,
  output logic [7:0]      core_key_in,
  input  logic            core_valid,
  input  logic [7:0]      core_byte_out,
  output logic            core_reset_n
);

  state_t         r_state;
  state_t         w_next;
  logic           w_accept;
  logic           w_any;
  logic           w_id;
  logic           r_ptr;
  logic           r_gnt;
  logic [3:0]     r_bcnt;
  logic [3:0]     r_ocnt;
  logic [95:0]    r_pt;
  logic [127:0]   r_key;
  logic [95:0]    r_ct;

`ifdef PYJ_ARB_TIMEOUT_EN
  logic           w_timeout;
  logic [15:0]    r_wcnt;
  logic           r_err;
  logic           r_core_pulse;
`else
  logic           w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  pyjamask96_rr2 u_rr2 (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_id  (w_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_ct       = '0;
    rsp_err      = 1'b0;
    core_load    = 1'b0;
    core_start   = 1'b0;
    core_byte_in = 8'h00;
    core_key_in  = 8'h00;
`ifdef PYJ_ARB_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any && !reset) begin
          w_accept        = 1'b1;
          req_ready[w_id] = 1'b1;
          w_next          = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_load    = (r_bcnt == 4'd0);
        core_key_in  = r_key[127:120];
        core_byte_in = (r_bcnt < 4'(PT_BYTES)) ? r_pt[95:88] : 8'h00;
        if (r_bcnt == 4'(KEY_BYTES - 1)) begin
          w_next = ST_START;
        end
      end
      ST_START: begin
        core_start = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_valid) begin
          w_next = ST_COLLECT;
        end
`ifdef PYJ_ARB_TIMEOUT_EN
        else if (r_wcnt >= 16'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_RESP;
        end
`endif
      end
      ST_COLLECT: begin
        if (core_valid && (r_ocnt == 4'(CT_BYTES - 1))) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[r_gnt] = 1'b1;
        rsp_ct           = r_ct;
`ifdef PYJ_ARB_TIMEOUT_EN
        rsp_err          = r_err;
`endif
        if (rsp_ready[r_gnt]) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operands shift out MSB byte first; result fills LSB byte first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= 1'b0;
      r_gnt  <= 1'b0;
      r_bcnt <= 4'd0;
      r_ocnt <= 4'd0;
      r_pt   <= '0;
      r_key  <= '0;
      r_ct   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt  <= w_id;
            r_pt   <= w_id ? req_pt1 : req_pt0;
            r_key  <= w_id ? req_key1 : req_key0;
            r_bcnt <= 4'd0;
            r_ocnt <= 4'd0;
            r_ct   <= '0;
          end
        end
        ST_LOAD: begin
          r_bcnt <= r_bcnt + 4'd1;
          r_pt   <= {r_pt[87:0], 8'h00};
          r_key  <= {r_key[119:0], 8'h00};
        end
        ST_WAIT: begin
          if (core_valid) begin
            r_ct[7:0] <= core_byte_out;
            r_ocnt    <= 4'd1;
          end
        end
        ST_COLLECT: begin
          if (core_valid) begin
            r_ct[{r_ocnt, 3'b000} +: 8] <= core_byte_out;
            r_ocnt                      <= r_ocnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_gnt]) begin
            r_ptr <= ~r_gnt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PYJ_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt       <= 16'd0;
      r_err        <= 1'b0;
      r_core_pulse <= 1'b0;
    end else begin
      r_core_pulse <= 1'b0;
      if (w_accept) begin
        r_err <= 1'b0;
      end
      if (r_state == ST_START) begin
        r_wcnt <= 16'd0;
      end else if (r_state == ST_WAIT && r_wcnt != 16'hFFFF) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
      if (w_timeout) begin
        r_err        <= 1'b1;
        r_core_pulse <= 1'b1;
      end
    end
  end

  assign core_reset_n = ~reset & ~r_core_pulse;
`else
  assign core_reset_n = ~reset;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pyjamask96_arbiter.sv
// ============================================================================
// tb_pyjamask96_arbiter : directed vector bench for pyjamask96_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pyjamask96_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [95:0]  req_pt0, req_pt1, rsp_ct;
  logic [127:0] req_key0, req_key1;
  logic         rsp_err, core_load, core_start, core_valid, core_reset_n;
  logic [7:0]   core_byte_in, core_key_in, core_byte_out;
  int           total = 0;
  int           bad   = 0;

  localparam logic [95:0]  PT1  = 96'h00112233445566778899AABB;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [95:0]  PTA  = 96'hDEADBEEFCAFEF00D12345678;
  localparam logic [95:0]  PTB  = 96'h0123456789ABCDEF55AA33CC;
  localparam logic [127:0] KEYA = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] KEYB = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [95:0]  CT01 = 96'h0C0B0A090807060504030201;
  localparam logic [95:0]  CT10 = 96'h1B1A19181716151413121110;
  localparam logic [95:0]  CTA0 = 96'hABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [95:0]  CTF8 = 96'h03020100FFFEFDFCFBFAF9F8;

  typedef struct {
    logic [1:0]   rv;
    logic [95:0]  pt0;
    logic [95:0]  pt1;
    logic [127:0] key0;
    logic [127:0] key1;
    logic [7:0]   base;
    int           gnt;
    logic [95:0]  ct;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  pyjamask96_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pt0       (req_pt0),
    .req_pt1       (req_pt1),
    .req_key0      (req_key0),
    .req_key1      (req_key1),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_ct        (rsp_ct),
    .rsp_err       (rsp_err),
    .core_load     (core_load),
    .core_start    (core_start),
    .core_byte_in  (core_byte_in),
    .core_key_in   (core_key_in),
    .core_valid    (core_valid),
    .core_byte_out (core_byte_out),
    .core_reset_n  (core_reset_n)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left just after a rising edge; the core side is modelled inline
  task automatic run_txn(input logic [1:0] rv, input logic [95:0] pt0, input logic [95:0] pt1,
                         input logic [127:0] key0, input logic [127:0] key1, input int gnt,
                         input int lat, input logic [7:0] base, input int gap_at, input int gap_len,
                         input int hold, input int abort_at, input logic [95:0] exp_ct);
    logic [95:0]  pt;
    logic [127:0] key;
    logic [1:0]   oh;
    oh  = (gnt == 1) ? 2'b10 : 2'b01;
    pt  = (gnt == 1) ? pt1 : pt0;
    key = (gnt == 1) ? key1 : key0;
    req_pt0 = pt0; req_pt1 = pt1; req_key0 = key0; req_key1 = key1;
    req_valid = rv;
    @(negedge clk);
    chk("accept_ready", req_ready, oh);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("load_strobe", core_load, (i == 0));
      chk("key_byte", core_key_in, key[127-8*i -: 8]);
      chk("pt_byte", core_byte_in, (i < 12) ? pt[95-8*i -: 8] : 8'h00);
      step();
    end
    @(negedge clk);
    chk("start_strobe", {core_start, core_load}, 2'b10);
    step();
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk("wait_quiet", {rsp_valid, core_reset_n, req_ready}, 5'b00100);
      step();
    end
    for (int j = 0; j < 12; j++) begin
      if (j == abort_at) begin
        core_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("abort_outputs", {req_ready, rsp_valid, rsp_ct, rsp_err, core_load, core_start,
                              core_byte_in, core_key_in, core_reset_n}, '0);
        step();
        reset = 1'b0;
        step();
        return;
      end
      if (j == gap_at) begin
        repeat (gap_len) begin
          core_valid = 1'b0;
          step();
        end
      end
      core_valid    = 1'b1;
      core_byte_out = base + 8'(j);
      step();
    end
    core_valid = 1'b0;
    core_byte_out = 8'h00;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        req_valid = oh;
        rsp_ready = ~oh;
      end
      @(negedge clk);
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_ct", rsp_ct, exp_ct);
      chk("rsp_err", rsp_err, 1'b0);
      if (h > 0) chk("held_off", req_ready, 2'b00);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = oh;
    @(negedge clk);
    chk("rsp_valid_ack", rsp_valid, oh);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("rsp_done", rsp_valid, 2'b00);
    step();
  endtask

  initial begin
    vecs[0] = '{2'b11, PTA, PTB, KEYA, KEYB, 8'h10, 0, CT10};
    vecs[1] = '{2'b11, PTA, PTB, KEYA, KEYB, 8'hA0, 1, CTA0};
    vecs[2] = '{2'b11, PTB, PTA, KEYB, KEYA, 8'hF8, 0, CTF8};
    vecs[3] = '{2'b11, PTB, PTA, KEYB, KEYA, 8'h01, 1, CT01};
    vecs[4] = '{2'b10, PTA, PTB, KEYA, KEYB, 8'h10, 1, CT10};
    vecs[5] = '{2'b01, PTB, PTA, KEYA, KEYB, 8'hA0, 0, CTA0};
    vecs[6] = '{2'b11, PTA, PTB, KEYB, KEYA, 8'hF8, 1, CTF8};

    reset = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_pt0 = '0; req_pt1 = '0; req_key0 = '0; req_key1 = '0;
    core_valid = 1'b0; core_byte_out = 8'h00;
    repeat (2) step();
    @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_ct, rsp_err, core_load, core_start,
                          core_byte_in, core_key_in, core_reset_n}, '0);
    req_valid = 2'b00;
    step();
    reset = 1'b0;
    step();

    // Single requester, 30-cycle core, response held 5 cycles
    run_txn(2'b01, PT1, PTA, KEY1, KEYA, 0, 30, 8'h01, -1, 0, 5, -1, CT01);

    // Fresh reset so the round-robin pointer starts at requester 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 7; k++) begin
      run_txn(vecs[k].rv, vecs[k].pt0, vecs[k].pt1, vecs[k].key0, vecs[k].key1,
              vecs[k].gnt, 2 + k, vecs[k].base, -1, 0, 0, -1, vecs[k].ct);
    end

    // Two-cycle core_valid gap mid-collection
    run_txn(2'b01, PT1, PTA, KEY1, KEYA, 0, 5, 8'h01, 5, 2, 0, -1, CT01);

    // Request withdrawn before any clock edge sees it
    req_valid = 2'b10;
    #3 req_valid = 2'b00;
    @(negedge clk);
    chk("drop_no_ready", req_ready, 2'b00);
    step();
    @(negedge clk);
    chk("drop_no_load", core_load, 1'b0);
    step();

    // Reset during collection at ocnt=7, then a clean transaction
    run_txn(2'b10, PTA, PTB, KEYA, KEYB, 1, 4, 8'h01, -1, 0, 0, 7, CT01);
    run_txn(2'b10, PTA, PTB, KEYA, KEYB, 1, 4, 8'h01, -1, 0, 0, -1, CT01);

    // Core silent well past the watchdog limit: no timeout in this build
    run_txn(2'b01, PTB, PTA, KEYB, KEYA, 0, 100, 8'h10, -1, 0, 0, -1, CT10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
